// File: rtl/mem_bus_arbiter_if.sv
// Port bundle for mem_bus_arbiter: I-fetch port, load/store port, memory bus
// and the pipeline stall output.
// master: the arbiter side.  slave: the pipeline/memory side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // instruction-fetch port
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic [DATA_W-1:0] inst_rdata;
   logic              inst_ready;

   // load/store port
   logic              data_req;
   logic              data_wr;
   logic [BE_W-1:0]   data_be;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              data_ready;

   // memory bus
   logic              bus_err;
   logic              bus_req;
   logic              bus_wr;
   logic [BE_W-1:0]   bus_be;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   // pipeline hazard controller
   logic              mem_stall;

   modport master (
      input  inst_req, inst_addr,
      output inst_rdata, inst_ready,
      input  data_req, data_wr, data_be, data_addr, data_wdata,
      output data_rdata, data_ready,
      output bus_err, bus_req, bus_wr, bus_be, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack,
      output mem_stall
   );

   modport slave (
      output inst_req, inst_addr,
      input  inst_rdata, inst_ready,
      output data_req, data_wr, data_be, data_addr, data_wdata,
      input  data_rdata, data_ready,
      input  bus_err, bus_req, bus_wr, bus_be, bus_addr, bus_wdata,
      output bus_rdata, bus_ack,
      input  mem_stall
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the fetch (I)
// and load/store (D) ports, one transaction at a time:
// IDLE -> BUSY_I/BUSY_D -> RESP -> IDLE.
// Optional macro MEM_ARB_RR_EN: round-robin between I and D when both request;
// without it D has fixed priority over I.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst_n,
   mem_bus_arbiter_if.master  bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_wr_q, bus_wr_d;
   logic [BE_W-1:0]   bus_be_q, bus_be_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              inst_ready_q, inst_ready_d;
   logic              data_ready_q, data_ready_d;
   logic              bus_err_q, bus_err_d;

   logic              pick_d;     // IDLE grant goes to D this cycle
   logic [CNT_W-1:0]  cnt_inc;
   logic              timeout_hit;
   logic [DATA_W-1:0] resp_data;

`ifdef MEM_ARB_RR_EN
   logic last_d_q, last_d_d;      // 1: D was served in the most recent RESP

   // Both requesting: serve whoever was not served last; else the lone requester
   always_comb begin
      pick_d = bus.data_req & (~bus.inst_req | ~last_d_q);
   end

   // Remember who got the response; reset value means "I was last"
   always_comb begin
      last_d_d = last_d_q;
      if (state_q == RESP) last_d_d = data_ready_q;
   end

   // Round-robin history register
   always_ff @(posedge clk) begin
      if (!rst_n) last_d_q <= 1'b0;
      else        last_d_q <= last_d_d;
   end
`else
   // Fixed priority: D always beats I
   always_comb begin
      pick_d = bus.data_req;
   end
`endif

   // Next state, command register and response capture
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_be_d     = bus_be_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_ready_d = 1'b0;
      data_ready_d = 1'b0;
      bus_err_d    = 1'b0;
      cnt_inc      = cnt_q + 1'b1;
      timeout_hit  = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);
      // stores and aborted transactions return zero
      resp_data    = (bus.bus_ack && !bus_wr_q) ? bus.bus_rdata : '0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_d) begin
               state_d     = BUSY_D;
               bus_req_d   = 1'b1;
               bus_wr_d    = bus.data_wr;
               bus_be_d    = bus.data_wr ? bus.data_be : '1;
               bus_addr_d  = bus.data_addr;
               bus_wdata_d = bus.data_wr ? bus.data_wdata : '0;
            end else if (bus.inst_req) begin
               state_d     = BUSY_I;
               bus_req_d   = 1'b1;
               bus_wr_d    = 1'b0;
               bus_be_d    = '1;
               bus_addr_d  = bus.inst_addr;
               bus_wdata_d = '0;
            end
         end
         BUSY_I, BUSY_D: begin
            // an ack in the same cycle as the limit still completes normally
            if (bus.bus_ack || timeout_hit) begin
               state_d   = RESP;
               bus_req_d = 1'b0;
               bus_err_d = ~bus.bus_ack;
               if (state_q == BUSY_D) begin
                  data_rdata_d = resp_data;
                  data_ready_d = 1'b1;
               end else begin
                  inst_rdata_d = resp_data;
                  inst_ready_d = 1'b1;
               end
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_be_q     <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_ready_q <= 1'b0;
         data_ready_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_be_q     <= bus_be_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_ready_q <= inst_ready_d;
         data_ready_q <= data_ready_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus.bus_req    = bus_req_q;
   assign bus.bus_wr     = bus_wr_q;
   assign bus.bus_be     = bus_be_q;
   assign bus.bus_addr   = bus_addr_q;
   assign bus.bus_wdata  = bus_wdata_q;
   assign bus.inst_rdata = inst_rdata_q;
   assign bus.data_rdata = data_rdata_q;
   assign bus.inst_ready = inst_ready_q;
   assign bus.data_ready = data_ready_q;
   assign bus.bus_err    = bus_err_q;

   // Stall drops in the cycle the requester sees its ready
   assign bus.mem_stall = (bus.inst_req & ~inst_ready_q) | (bus.data_req & ~data_ready_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// arbitration/reset sequences, then randomized traffic against a
// transaction-timeline reference model.
module tb_mem_bus_arbiter;
   localparam int TO       = 4;
   localparam int RAND_CYC = 600;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;    // what the bus returns with ack
      int          lat;      // cycles after the first bus_req cycle before ack
      logic [3:0]  x_be;
      logic [31:0] x_rdata;
      bit          x_err;
   } vec_t;

   vec_t vt[6];

   task automatic clear_inputs();
      bif.inst_req   = 1'b0;
      bif.inst_addr  = '0;
      bif.data_req   = 1'b0;
      bif.data_wr    = 1'b0;
      bif.data_be    = '0;
      bif.data_addr  = '0;
      bif.data_wdata = '0;
      bif.bus_rdata  = '0;
      bif.bus_ack    = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One transaction from a lone requester; caller is at a negedge with DUT idle
   task automatic run_one(input vec_t v, input string nm);
      int nb;
      nb = (v.lat + 1 <= TO) ? v.lat + 1 : TO;
      if (v.is_d) begin
         bif.data_req   = 1'b1;
         bif.data_wr    = v.wr;
         bif.data_be    = v.be;
         bif.data_addr  = v.addr;
         bif.data_wdata = v.wdata;
      end else begin
         bif.inst_req  = 1'b1;
         bif.inst_addr = v.addr;
      end
      #1 chk({nm, " stall on request"}, bif.mem_stall, 1);
      for (int k = 1; k <= nb; k++) begin
         @(negedge clk);
         bif.bus_ack = 1'b0;
         chk({nm, " bus_req"}, bif.bus_req, 1);
         chk({nm, " bus_addr"}, bif.bus_addr, v.addr);
         chk({nm, " bus_be"}, bif.bus_be, v.x_be);
         chk({nm, " bus_wr"}, bif.bus_wr, v.wr);
         if (v.wr) chk({nm, " bus_wdata"}, bif.bus_wdata, v.wdata);
         chk({nm, " no early ready"}, {bif.inst_ready, bif.data_ready}, 2'b00);
         chk({nm, " stall while busy"}, bif.mem_stall, 1);
         if (k == v.lat + 1) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = v.rdata;
         end
      end
      @(negedge clk);
      bif.bus_ack = 1'b0;
      chk({nm, " bus_req dropped"}, bif.bus_req, 0);
      chk({nm, " ready"}, {bif.inst_ready, bif.data_ready}, {~v.is_d, v.is_d});
      chk({nm, " rdata"}, v.is_d ? bif.data_rdata : bif.inst_rdata, v.x_rdata);
      chk({nm, " bus_err"}, bif.bus_err, v.x_err);
      chk({nm, " stall released"}, bif.mem_stall, 0);
      bif.inst_req = 1'b0;
      bif.data_req = 1'b0;
      @(negedge clk);
      chk({nm, " ready one cycle"}, {bif.inst_ready, bif.data_ready, bif.bus_err}, 3'b000);
   endtask

   // Both ports request loads; bus acks in the first bus_req cycle.
   // hold=1 keeps both requests up so each ready starts a new transaction.
   int ord[4];
   int tm[4];
   task automatic both_req(input int ntx, input bit hold);
      int got;
      int cyc;
      got = 0;
      cyc = 0;
      bif.inst_req  = 1'b1;
      bif.inst_addr = 32'h500;
      bif.data_req  = 1'b1;
      bif.data_wr   = 1'b0;
      bif.data_addr = 32'h600;
      while (got < ntx && cyc < 60) begin
         @(negedge clk);
         cyc++;
         bif.bus_ack = 1'b0;
         if (bif.inst_ready && got < 4) begin
            ord[got] = 0; tm[got] = cyc; got++;
            if (!hold) bif.inst_req = 1'b0;
         end
         if (bif.data_ready && got < 4) begin
            ord[got] = 1; tm[got] = cyc; got++;
            if (!hold) bif.data_req = 1'b0;
         end
         if (bif.bus_req) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = $urandom;
         end
      end
      chk("both: all transactions completed", got, ntx);
      bif.inst_req = 1'b0;
      bif.data_req = 1'b0;
      bif.bus_ack  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // reference model state for the random phase
   int          k, t_g, a_g, lat;
   bit          busy, own_d, err_e, last_d, win_d;
   bit          e_br, e_ir, e_dr;
   bit          exp_wr;
   logic [3:0]  exp_be;
   logic [31:0] exp_addr, exp_wd, exp_rd, ack_rd;
   bit          ip, dp, dwr;
   logic [31:0] ia, da, dwd;
   logic [3:0]  dbe;

   initial begin
      vt[0] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 4'hF, 32'hDEADBEEF, 1'b0};
      vt[1] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00000013, 0, 4'hF, 32'h00000013, 1'b0};
      vt[2] = '{1'b1, 1'b1, 4'h3, 32'h204, 32'h12345678, 32'hAAAA5555, 1, 4'h3, 32'h0, 1'b0};
      vt[3] = '{1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 32'h11111111, 99, 4'hF, 32'h0, 1'b1};
      vt[4] = '{1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D, TO - 1, 4'hF, 32'hCAFEF00D, 1'b0};
      vt[5] = '{1'b0, 1'b0, 4'h0, 32'h80, 32'h0, 32'h22222222, 99, 4'hF, 32'h0, 1'b1};

      do_reset();
      // reset state
      chk("reset bus_req", bif.bus_req, 0);
      chk("reset ready", {bif.inst_ready, bif.data_ready}, 2'b00);
      chk("reset bus_err", bif.bus_err, 0);
      chk("reset bus_addr", bif.bus_addr, 0);
      chk("reset bus_be", bif.bus_be, 0);
      chk("reset inst_rdata", bif.inst_rdata, 0);
      chk("reset data_rdata", bif.data_rdata, 0);
      chk("reset mem_stall", bif.mem_stall, 0);

      for (int i = 0; i < 6; i++) run_one(vt[i], $sformatf("vec%0d", i));

      // reset during BUSY_D abandons the load
      bif.data_req  = 1'b1;
      bif.data_wr   = 1'b0;
      bif.data_addr = 32'h400;
      @(negedge clk);
      chk("rst-busy bus_req up", bif.bus_req, 1);
      @(negedge clk);
      chk("rst-busy bus_req held", bif.bus_req, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst-busy bus_req cleared", bif.bus_req, 0);
      chk("rst-busy no ready", bif.data_ready, 0);
      rst_n = 1'b1;
      bif.data_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst-busy stays quiet", {bif.bus_req, bif.data_ready}, 2'b00);
      end
      run_one(vt[1], "post-reset fetch");

`ifdef MEM_ARB_RR_EN
      do_reset();
      both_req(4, 1'b1);
      chk("rr grant 0 is D", ord[0], 1);
      chk("rr grant 1 is I", ord[1], 0);
      chk("rr grant 2 is D", ord[2], 1);
      chk("rr grant 3 is I", ord[3], 0);
`else
      do_reset();
      both_req(2, 1'b0);
      chk("prio first is D", ord[0], 1);
      chk("prio second is I", ord[1], 0);
      chk("prio I ready 3 cycles after D", tm[1] - tm[0], 3);
`endif

      // randomized traffic against the timeline model
      do_reset();
      k = 0; busy = 0; t_g = -10; a_g = -10; last_d = 0; own_d = 0; err_e = 0;
      ip = 0; dp = 0; ia = '0; da = '0; dwd = '0; dbe = 4'hF; dwr = 0;
      exp_wr = 0; exp_be = 4'hF; exp_addr = '0; exp_wd = '0; exp_rd = '0; ack_rd = '0;
      repeat (RAND_CYC) begin
         e_br = busy && k >= t_g && k < a_g;
         e_ir = busy && k == a_g && !own_d;
         e_dr = busy && k == a_g && own_d;
         chk("rnd bus_req", bif.bus_req, e_br);
         chk("rnd ready", {bif.inst_ready, bif.data_ready}, {e_ir, e_dr});
         chk("rnd bus_err", bif.bus_err, (e_ir | e_dr) & err_e);
         if (e_ir) chk("rnd inst_rdata", bif.inst_rdata, exp_rd);
         if (e_dr) chk("rnd data_rdata", bif.data_rdata, exp_rd);
         if (e_br) begin
            chk("rnd bus_addr", bif.bus_addr, exp_addr);
            chk("rnd bus_be", bif.bus_be, exp_be);
            chk("rnd bus_wr", bif.bus_wr, exp_wr);
            if (exp_wr) chk("rnd bus_wdata", bif.bus_wdata, exp_wd);
         end
         if (e_ir) ip = 0;
         if (e_dr) dp = 0;
         if (e_ir || e_dr) last_d = own_d;
         if (busy && k >= a_g + 1) busy = 0;

         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; ia = $urandom;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; dwr = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(1, 15));
            da = $urandom; dwd = $urandom;
         end
         bif.inst_req   = ip;
         bif.inst_addr  = ia;
         bif.data_req   = dp;
         bif.data_wr    = dwr;
         bif.data_be    = dbe;
         bif.data_addr  = da;
         bif.data_wdata = dwd;

         bif.bus_ack   = 1'b0;
         bif.bus_rdata = $urandom;
         if (!busy && (ip || dp)) begin
`ifdef MEM_ARB_RR_EN
            win_d = dp && (!ip || !last_d);
`else
            win_d = dp;
`endif
            own_d = win_d;
            t_g   = k + 1;
            lat   = $urandom_range(0, 5);
            if (win_d) begin
               exp_wr = dwr; exp_be = dwr ? dbe : 4'hF; exp_addr = da; exp_wd = dwd;
            end else begin
               exp_wr = 0; exp_be = 4'hF; exp_addr = ia; exp_wd = '0;
            end
            if (lat + 1 <= TO) begin
               a_g = t_g + 1 + lat; err_e = 0; ack_rd = $urandom;
               exp_rd = exp_wr ? 32'h0 : ack_rd;
            end else begin
               a_g = t_g + TO; err_e = 1; exp_rd = 32'h0;
            end
            busy = 1;
         end
         if (busy && !err_e && k + 1 == a_g) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = ack_rd;
         end else if (!(busy && k + 1 >= t_g + 1 && k + 1 <= a_g) && $urandom_range(0, 5) == 0) begin
            bif.bus_ack = 1'b1;   // stray ack outside BUSY must be ignored
         end
         #1 chk("rnd mem_stall", bif.mem_stall, (ip & ~e_ir) | (dp & ~e_dr));
         @(negedge clk);
         k++;
      end

      clear_inputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (I) and the load/store port (D).
- Sequences one transaction at a time: arbitration, command hold, response capture, optional timeout.
- Produces mem_stall for the pipeline hazard/enable controller.
- Sits between the IF/MEM stages and the external memory bus.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, maximum cycles waiting for bus_ack before aborting a transaction; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- inst_req  in  1  fetch request, level-held until inst_ready.
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  DATA_W  fetched word, valid while inst_ready=1.
- inst_ready  out  1  one-cycle completion pulse for I.
- data_req  in  1  load/store request, level-held until data_ready.
- data_wr  in  1  1=store, 0=load.
- data_be  in  DATA_W/8  store byte enables.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load data, valid while data_ready=1.
- data_ready  out  1  one-cycle completion pulse for D.
- bus_err  out  1  one-cycle pulse, coincident with ready, when the transaction timed out.
- bus_req  out  1  bus command valid.
- bus_wr  out  1  bus write.
- bus_be  out  DATA_W/8  bus byte enables; all ones for reads.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion from the bus.
- mem_stall  out  1  combinational: (inst_req & ~inst_ready) | (data_req & ~data_ready).

Behaviour:
- **Reset.** Synchronous on rising clk with rst_n=0.
  - FSM goes to IDLE.
  - All registered outputs (bus_*, *_ready, *_rdata, bus_err) clear to 0; the wait counter clears to 0.
  - Reset mid-transaction abandons the transaction; no ready pulse is issued.
- **IDLE.**
  - data_req=1: latch D command into the command register, go to BUSY_D.
  - Else inst_req=1: latch I command, go to BUSY_I.
  - Both requests present: D wins (fixed priority).
- **BUSY_I / BUSY_D.**
  - bus_req=1; bus_addr/wr/be/wdata come from the command register and stay stable until ack.
  - On bus_ack:
    - capture bus_rdata (stores capture 0) into the granted port's rdata;
    - deassert bus_req next cycle;
    - go to RESP.
  - The wait counter increments each BUSY cycle without ack.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT: abort, rdata=0, set the err flag, go to RESP.
- **RESP** (one cycle).
  - Granted port's ready=1; bus_err=flag; then go to IDLE and clear the counter and flag.
  - In this cycle the requester's ready=1, so mem_stall drops for it.
  - A req still high in the following IDLE cycle is a new transaction.
- **Latency.** Request seen in IDLE cycle t → bus_req at t+1 → ack at cycle a≥t+1 → ready at a+1. Minimum request-to-ready is 2 cycles.
- **Back-to-back.**
  - Minimum 3 cycles per transaction: IDLE, BUSY, RESP.
  - The losing requester is served in the next IDLE.
- Requests are never preempted once granted.
- bus_ack outside BUSY is ignored.
- The command register is sampled only in IDLE; port changes during BUSY have no effect.
- Counter width is ≥ clog2(TIMEOUT+1); no wrap before TIMEOUT.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - a last_grant register (reset: I) records the port served in each RESP;
  - when both requests are present in IDLE, grant goes to the port not equal to last_grant;
  - a single request is granted directly.
- Undefined: fixed D-over-I priority; no last_grant register.

Test Plan:
- **Lone load.** data_req=1, wr=0, addr=0x100; bus acks 2 cycles after bus_req with rdata=0xDEADBEEF → bus_addr=0x100, bus_be=4'hF; data_ready pulse 1 cycle after ack with data_rdata=0xDEADBEEF; mem_stall high until the ready cycle.
- **Lone fetch, zero-wait ack.** inst_req=1, addr=0x0; ack in the first bus_req cycle → inst_ready exactly 2 cycles after the request is seen in IDLE; bus_req high for 1 cycle.
- **Store.** data_wr=1, be=4'b0011, wdata=0x12345678, addr=0x204 → bus_wr=1, bus_be=4'b0011, wdata stable until ack; data_rdata=0; data_ready once.
- **Simultaneous requests, no macro.** inst_req and data_req rise together → D served first, then I; I's ready arrives ≥3 cycles after D's.
- **Simultaneous requests, MEM_ARB_RR_EN.** Both requests held for 4 transactions → grants alternate D, I, D, I starting after reset (last_grant=I).
- **Timeout and reset.**
  - TIMEOUT=4, no ack → bus_req high 4 cycles, then ready with rdata=0 and bus_err=1.
  - rst_n=0 during BUSY_D → next cycle bus_req=0, no data_ready, FSM in IDLE.
